// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: default element width and the
// flat-index helper used to address elements inside a flattened volume.
package cnn_pkg;

    localparam int CNN_DATA_WIDTH = 16;

    // Element (d,r,c) of an h x w x depth volume; element 0 sits in the LSBs.
    function automatic int flat_idx(input int d, input int r, input int c,
                                    input int h, input int w);
        return d * h * w + r * w + c;
    endfunction

endpackage

// File: rtl/fp_max2.sv
// Combinational max of two sign-magnitude floats, decided from the bits alone.
// Equal values (including +0 against -0) return the first operand.
module fp_max2
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    output logic [DATA_WIDTH-1:0] max_o
);

    logic                  x_neg_s;
    logic                  y_neg_s;
    logic [DATA_WIDTH-2:0] x_mag_s;
    logic [DATA_WIDTH-2:0] y_mag_s;
    logic                  y_wins_s;

    assign x_neg_s = x[DATA_WIDTH-1];
    assign y_neg_s = y[DATA_WIDTH-1];
    assign x_mag_s = x[DATA_WIDTH-2:0];
    assign y_mag_s = y[DATA_WIDTH-2:0];

    // Pick y only when it is strictly larger; two zeros of either sign tie.
    always_comb begin
        y_wins_s = 1'b0;
        if ((x_mag_s == '0) && (y_mag_s == '0)) begin
            y_wins_s = 1'b0;
        end else if (x_neg_s != y_neg_s) begin
            y_wins_s = x_neg_s;
        end else if (!x_neg_s) begin
            y_wins_s = (y_mag_s > x_mag_s);
        end else begin
            y_wins_s = (y_mag_s < x_mag_s);
        end
    end

    assign max_o = y_wins_s ? y : x;

endmodule

// File: rtl/max_pool_single.sv
// 2x2 stride-2 max-pooling over a whole flattened volume: every window is
// reduced in parallel and the pooled volume is registered once.
module max_pool_single
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int InputH     = 28,
    parameter int InputW     = 28,
    parameter int Depth      = 1
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  in_valid,
    input  logic [InputH*InputW*Depth*DATA_WIDTH-1:0]             aPoolIn,
    output logic                                                  out_valid,
    output logic [(InputH/2)*(InputW/2)*Depth*DATA_WIDTH-1:0]     aPoolOut
);

    localparam int OH       = InputH / 2;
    localparam int OW       = InputW / 2;
    localparam int OUT_BITS = OH * OW * Depth * DATA_WIDTH;

    logic [OUT_BITS-1:0] pooled_s;
    logic [OUT_BITS-1:0] aPoolOut_d;
    logic [OUT_BITS-1:0] aPoolOut_q;
    logic                out_valid_d;
    logic                out_valid_q;

    // Odd trailing rows/columns are never addressed by any window.
    for (genvar d = 0; d < Depth; d++) begin : g_depth
        for (genvar r = 0; r < OH; r++) begin : g_row
            for (genvar c = 0; c < OW; c++) begin : g_col
                localparam int IA = flat_idx(d, 2*r,     2*c,     InputH, InputW);
                localparam int IB = flat_idx(d, 2*r,     2*c + 1, InputH, InputW);
                localparam int IE = flat_idx(d, 2*r + 1, 2*c,     InputH, InputW);
                localparam int IF = flat_idx(d, 2*r + 1, 2*c + 1, InputH, InputW);
                localparam int IO = flat_idx(d, r, c, OH, OW);

                logic [DATA_WIDTH-1:0] top_max_s;
                logic [DATA_WIDTH-1:0] bot_max_s;

                fp_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_top (
                    .x     (aPoolIn[IA*DATA_WIDTH +: DATA_WIDTH]),
                    .y     (aPoolIn[IB*DATA_WIDTH +: DATA_WIDTH]),
                    .max_o (top_max_s)
                );

                fp_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_bot (
                    .x     (aPoolIn[IE*DATA_WIDTH +: DATA_WIDTH]),
                    .y     (aPoolIn[IF*DATA_WIDTH +: DATA_WIDTH]),
                    .max_o (bot_max_s)
                );

                fp_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_win (
                    .x     (top_max_s),
                    .y     (bot_max_s),
                    .max_o (pooled_s[IO*DATA_WIDTH +: DATA_WIDTH])
                );
            end
        end
    end

    // Capture a new pooled volume on valid input, otherwise hold the last one.
    always_comb begin
        aPoolOut_d  = aPoolOut_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            aPoolOut_d  = pooled_s;
            out_valid_d = 1'b1;
        end else begin
            aPoolOut_d  = aPoolOut_q;
            out_valid_d = 1'b0;
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            aPoolOut_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            aPoolOut_q  <= aPoolOut_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign aPoolOut  = aPoolOut_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_max_pool_single.sv
// Directed bench for max_pool_single across four geometries sharing one clock.
module tb_max_pool_single;

    logic clk;
    logic reset;

    logic              v_big, v_sgn, v_pos, v_odd;
    logic              ov_big, ov_sgn, ov_pos, ov_odd;
    logic [12543:0]    in_big;
    logic [3135:0]     out_big;
    logic [127:0]      in_sgn;
    logic [31:0]       out_sgn;
    logic [511:0]      in_pos;
    logic [127:0]      out_pos;
    logic [399:0]      in_odd;
    logic [63:0]       out_odd;

    int checks;
    int failures;

    logic [15:0] exp_a [8];
    logic [15:0] exp_b [8];

    max_pool_single #(.DATA_WIDTH(16), .InputH(28), .InputW(28), .Depth(1)) u_big (
        .clk(clk), .reset(reset), .in_valid(v_big), .aPoolIn(in_big),
        .out_valid(ov_big), .aPoolOut(out_big));

    max_pool_single #(.DATA_WIDTH(16), .InputH(2), .InputW(4), .Depth(1)) u_sgn (
        .clk(clk), .reset(reset), .in_valid(v_sgn), .aPoolIn(in_sgn),
        .out_valid(ov_sgn), .aPoolOut(out_sgn));

    max_pool_single #(.DATA_WIDTH(16), .InputH(4), .InputW(4), .Depth(2)) u_pos (
        .clk(clk), .reset(reset), .in_valid(v_pos), .aPoolIn(in_pos),
        .out_valid(ov_pos), .aPoolOut(out_pos));

    max_pool_single #(.DATA_WIDTH(16), .InputH(5), .InputW(5), .Depth(1)) u_odd (
        .clk(clk), .reset(reset), .in_valid(v_odd), .aPoolIn(in_odd),
        .out_valid(ov_odd), .aPoolOut(out_odd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small non-negative integer to binary16.
    function automatic logic [15:0] int2h(input int n);
        int e;
        logic [4:0] ex;
        logic [9:0] man;
        if (n == 0) return 16'h0000;
        e = 0;
        for (int k = 0; k < 16; k++) if (n >= (1 << k)) e = k;
        ex  = 5'(e + 15);
        man = 10'((n - (1 << e)) << (10 - e));
        return {1'b0, ex, man};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_a = '{16'h4500, 16'h4700, 16'h4A80, 16'h4B80, 16'h4D40, 16'h4DC0, 16'h4F40, 16'h4FC0};
        exp_b = '{16'h4FC0, 16'h4F40, 16'h4DC0, 16'h4D40, 16'h4B80, 16'h4A80, 16'h4700, 16'h4500};

        // Reset held with valid asserted and non-zero data on every instance.
        reset  = 1'b1;
        v_big  = 1'b1; v_sgn = 1'b1; v_pos = 1'b1; v_odd = 1'b1;
        in_big = {784{16'h4400}};
        in_sgn = {8{16'h3C00}};
        in_pos = {32{16'h4000}};
        in_odd = {25{16'h3C00}};
        step();
        step();
        chk("rst_ov_big", {15'd0, ov_big}, 16'd0);
        chk("rst_ov_sgn", {15'd0, ov_sgn}, 16'd0);
        chk("rst_ov_pos", {15'd0, ov_pos}, 16'd0);
        chk("rst_ov_odd", {15'd0, ov_odd}, 16'd0);
        chk("rst_out_big_or", {15'd0, |out_big}, 16'd0);
        chk("rst_out_sgn_or", {15'd0, |out_sgn}, 16'd0);
        chk("rst_out_pos_or", {15'd0, |out_pos}, 16'd0);
        chk("rst_out_odd_or", {15'd0, |out_odd}, 16'd0);

        // 28x28 alternating pattern; every window max is 5.0.
        reset = 1'b0;
        v_sgn = 1'b0; v_pos = 1'b0; v_odd = 1'b0;
        for (int r = 0; r < 28; r++) begin
            for (int c = 0; c < 28; c++) begin
                if (r % 2 == 0) in_big[(r*28+c)*16 +: 16] = (c % 2 == 0) ? 16'h4200 : 16'h4500;
                else            in_big[(r*28+c)*16 +: 16] = (c % 2 == 0) ? 16'h4400 : 16'h4000;
            end
        end
        v_big = 1'b1;
        step();
        chk("big_ov", {15'd0, ov_big}, 16'd1);
        for (int i = 0; i < 196; i++) chk($sformatf("big_out[%0d]", i), out_big[i*16 +: 16], 16'h4500);
        v_big  = 1'b0;
        in_big = {784{16'h3C00}};
        step();
        chk("big_ov_drop", {15'd0, ov_big}, 16'd0);
        chk("big_hold0", out_big[15:0], 16'h4500);
        chk("big_hold195", out_big[195*16 +: 16], 16'h4500);

        // Sign windows, positional A, and odd-size volume in the same cycle.
        in_sgn[0*16 +: 16] = 16'hC500; in_sgn[1*16 +: 16] = 16'hBC00;
        in_sgn[4*16 +: 16] = 16'h8000; in_sgn[5*16 +: 16] = 16'hC000;
        in_sgn[2*16 +: 16] = 16'h8000; in_sgn[3*16 +: 16] = 16'h0000;
        in_sgn[6*16 +: 16] = 16'hBC00; in_sgn[7*16 +: 16] = 16'hC000;
        for (int i = 0; i < 32; i++) in_pos[i*16 +: 16] = int2h(i);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                in_odd[(r*5+c)*16 +: 16] = (r == 4 || c == 4) ? 16'h7BFF : 16'h3C00;
        v_sgn = 1'b1; v_pos = 1'b1; v_odd = 1'b1;
        step();
        chk("sgn_ov", {15'd0, ov_sgn}, 16'd1);
        chk("sgn_win0", out_sgn[15:0], 16'h8000);
        chk("sgn_win1_tie", out_sgn[31:16], 16'h8000);
        chk("odd_ov", {15'd0, ov_odd}, 16'd1);
        for (int i = 0; i < 4; i++) chk($sformatf("odd_out[%0d]", i), out_odd[i*16 +: 16], 16'h3C00);
        chk("posA_ov", {15'd0, ov_pos}, 16'd1);
        for (int i = 0; i < 8; i++) chk($sformatf("posA_out[%0d]", i), out_pos[i*16 +: 16], exp_a[i]);

        // Volume B back-to-back: values descend with index.
        v_sgn = 1'b0; v_odd = 1'b0;
        for (int i = 0; i < 32; i++) in_pos[i*16 +: 16] = int2h(31 - i);
        step();
        chk("posB_ov", {15'd0, ov_pos}, 16'd1);
        for (int i = 0; i < 8; i++) chk($sformatf("posB_out[%0d]", i), out_pos[i*16 +: 16], exp_b[i]);
        chk("sgn_ov_drop", {15'd0, ov_sgn}, 16'd0);
        chk("sgn_hold", out_sgn[15:0], 16'h8000);

        // Reset during B output cycle clears everything.
        reset = 1'b1;
        v_pos = 1'b1;
        step();
        chk("mid_rst_ov", {15'd0, ov_pos}, 16'd0);
        chk("mid_rst_out_or", {15'd0, |out_pos}, 16'd0);
        reset = 1'b0;
        v_pos = 1'b0;
        step();
        chk("post_rst_ov", {15'd0, ov_pos}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
